// File: rtl/key_expansion.sv
// key_expansion: iterative AES-128 key schedule feeding AddRoundKey.
// A start request latches the cipher key into slot 0. Round keys 1..10 are
// then derived one per clock and held in an 11-entry store, which a
// registered read port serves in any order.
// Ports:
//   clk      - clock, all logic on rising edge
//   rst      - synchronous active-high reset
//   start    - request expansion of key (ignored while busy)
//   key      - cipher key, FIPS-197 byte order (byte 0 = key[127:120])
//   rd_addr  - round-key index 0..10 (11..15 read as zero)
//   rd_key   - registered round key selected by rd_addr, 1-cycle latency
//   busy     - expansion in progress
//   ready    - all 11 round keys valid
//   done     - one-cycle pulse when expansion completes
module key_expansion #(
  parameter int unsigned word_size  = 8,
  parameter int unsigned array_size = 16,
  parameter int unsigned num_rounds = 10
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic [word_size*array_size-1:0]   key,
  input  logic [3:0]                        rd_addr,
  output logic [word_size*array_size-1:0]   rd_key,
  output logic                              busy,
  output logic                              ready,
  output logic                              done
);

  localparam int unsigned block_w = word_size * array_size;
  localparam int unsigned depth   = num_rounds + 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_EXPAND = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  // AES forward S-box, entry 0 in the most significant byte.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  logic [block_w-1:0] store [depth];
  logic [1:0]         state, state_nxt;
  logic [3:0]         cnt, cnt_nxt;
  logic               busy_nxt, ready_nxt, done_nxt;
  logic               wr_en_c;
  logic [3:0]         wr_idx_c;
  logic [3:0]         prev_idx_c;
  logic [block_w-1:0] wr_data_c;
  logic [block_w-1:0] round_key_c;

  function automatic logic [7:0] sub_byte(input logic [7:0] b);
    sub_byte = SBOX[11'd2047 - {b, 3'b000} -: 8];
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  endfunction

  // One key-schedule round: word-wise XOR chain seeded by the transformed last word.
  function automatic logic [block_w-1:0] next_round(input logic [block_w-1:0] prev,
                                                    input logic [7:0]         rc);
    logic [31:0] p0, p1, p2, p3, rot, t, n0, n1, n2, n3;
    p0  = prev[127:96];
    p1  = prev[95:64];
    p2  = prev[63:32];
    p3  = prev[31:0];
    rot = {p3[23:0], p3[31:24]};
    t   = {sub_byte(rot[31:24]) ^ rc, sub_byte(rot[23:16]),
           sub_byte(rot[15:8]), sub_byte(rot[7:0])};
    n0  = p0 ^ t;
    n1  = p1 ^ n0;
    n2  = p2 ^ n1;
    n3  = p3 ^ n2;
    next_round = {n0, n1, n2, n3};
  endfunction

  // Guard keeps the previous-slot index in range while idle (cnt = 0).
  assign prev_idx_c  = (cnt == 4'd0) ? 4'd0 : cnt - 4'd1;
  assign round_key_c = next_round(store[prev_idx_c], rcon(cnt));

  // Next-state and store-write decode.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    busy_nxt  = busy;
    ready_nxt = ready;
    done_nxt  = 1'b0;
    wr_en_c   = 1'b0;
    wr_idx_c  = cnt;
    wr_data_c = round_key_c;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          wr_en_c   = 1'b1;
          wr_idx_c  = 4'd0;
          wr_data_c = key;
          cnt_nxt   = 4'd1;
          busy_nxt  = 1'b1;
          ready_nxt = 1'b0;
          state_nxt = S_EXPAND;
        end
      end
      S_EXPAND: begin
        wr_en_c = 1'b1;
        // Counter holds at the final round so it never exceeds num_rounds.
        if (cnt == 4'(num_rounds)) begin
          busy_nxt  = 1'b0;
          ready_nxt = 1'b1;
          done_nxt  = 1'b1;
          state_nxt = S_DONE;
        end else begin
          cnt_nxt = cnt + 4'd1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State, status and round-key store registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= 4'd0;
      busy  <= 1'b0;
      ready <= 1'b0;
      done  <= 1'b0;
      for (int i = 0; i < int'(depth); i++) store[i] <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      busy  <= busy_nxt;
      ready <= ready_nxt;
      done  <= done_nxt;
      if (wr_en_c) store[wr_idx_c] <= wr_data_c;
    end
  end

  // Registered read port, independent of FSM state.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_key <= '0;
    end else if (rd_addr < 4'(depth)) begin
      rd_key <= store[rd_addr];
    end else begin
      rd_key <= '0;
    end
  end

endmodule

// File: tb/tb_key_expansion.sv
// tb_key_expansion: directed bench for key_expansion. Expected read data is
// queued when an address is driven and popped when rd_key is sampled.
module tb_key_expansion;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [127:0] key = '0;
  logic [3:0]   rd_addr = '0;
  logic [127:0] rd_key;
  logic         busy, ready, done;

  int n_pass  = 0;
  int n_total = 0;

  logic [127:0] exp_q [$];
  string        tag_q [$];

  localparam logic [127:0] K_A1     = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] A1_R1    = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] A1_R2    = 128'hf2c295f27a96b9435935807a7359f67f;
  localparam logic [127:0] A1_R10   = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] K_SEQ    = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] SEQ_R10  = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam logic [127:0] ZERO_R1  = 128'h62636363626363636263636362636363;

  key_expansion dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .key     (key),
    .rd_addr (rd_addr),
    .rd_key  (rd_key),
    .busy    (busy),
    .ready   (ready),
    .done    (done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic rd(input string tag, input logic [3:0] addr, input logic [127:0] exp);
    rd_addr = addr;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    tick();
    chk(tag_q.pop_front(), rd_key, exp_q.pop_front());
  endtask

  task automatic do_start(input logic [127:0] k);
    key   = k;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Bounded wait for the done pulse; reports the number of edges taken.
  task automatic wait_done(input string tag, input int exp_cycles);
    int cyc;
    cyc = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (done === 1'b1) begin
        cyc = i;
        break;
      end
    end
    chk(tag, 128'(cyc), 128'(exp_cycles));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen_done;

    // Reset state
    rst = 1'b1;
    tick();
    tick();
    chk("reset_status", 128'({busy, ready, done}), 128'(3'b000));
    chk("reset_rd_key", rd_key, 128'h0);
    rst = 1'b0;

    // 1: FIPS-197 A.1 expansion with exact latency
    do_start(K_A1);
    chk("t1_e0_status", 128'({busy, done, ready}), 128'(3'b100));
    for (int k = 1; k <= 9; k++) begin
      tick();
      chk($sformatf("t1_e%0d_status", k), 128'({busy, done, ready}), 128'(3'b100));
    end
    tick();
    chk("t1_e10_status", 128'({busy, done, ready}), 128'(3'b011));
    tick();
    chk("t1_after_done", 128'({busy, done, ready}), 128'(3'b001));
    rd("t1_slot0", 4'd0, K_A1);
    rd("t1_slot1", 4'd1, A1_R1);
    rd("t1_slot2", 4'd2, A1_R2);
    rd("t1_slot10", 4'd10, A1_R10);

    // 2: pipelined reads across the valid/invalid address boundary
    rd_addr = 4'd10;
    exp_q.push_back(A1_R10);
    tag_q.push_back("t2_addr10");
    tick();
    rd_addr = 4'd11;
    exp_q.push_back(128'h0);
    tag_q.push_back("t2_addr11");
    chk(tag_q.pop_front(), rd_key, exp_q.pop_front());
    tick();
    chk(tag_q.pop_front(), rd_key, exp_q.pop_front());
    rd("t2_addr15", 4'd15, 128'h0);

    // 3: start while busy is ignored
    do_start(K_A1);
    repeat (3) tick();
    key   = K_SEQ;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("t3_done_edge", 6);
    chk("t3_ready", 128'(ready), 128'(1'b1));
    rd("t3_slot0", 4'd0, K_A1);
    rd("t3_slot10", 4'd10, A1_R10);

    // 5: restart from DONE with a new key
    do_start(K_SEQ);
    chk("t5_start_edge", 128'({busy, ready}), 128'(2'b10));
    wait_done("t5_done_edge", 10);
    rd("t5_slot0", 4'd0, K_SEQ);
    rd("t5_slot10", 4'd10, SEQ_R10);

    // 6: all-zero key
    do_start(128'h0);
    wait_done("t6_done_edge", 10);
    rd("t6_slot1", 4'd1, ZERO_R1);

    // 4: reset mid-expansion abandons the run and clears the store
    do_start(K_A1);
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t4_after_rst", 128'({busy, ready, done}), 128'(3'b000));
    seen_done = 1'b0;
    repeat (12) begin
      tick();
      if (done !== 1'b0) seen_done = 1'b1;
    end
    chk("t4_no_done", 128'(seen_done), 128'(1'b0));
    chk("t4_no_ready", 128'(ready), 128'(1'b0));
    rd("t4_slot0", 4'd0, 128'h0);
    rd("t4_slot10", 4'd10, 128'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/key_expansion.md
Name: key_expansion

Overview:
Iterative AES-128 key schedule that feeds the AddRoundKey stage.
- On a start request it latches the 128-bit cipher key and derives round keys 1..10, one round per clock.
- All 11 round keys are held in an internal store.
- A registered read port serves them in any order: ascending for encryption, descending for decryption.

Parameters:
word_size, 8, bits per state byte
array_size, 16, bytes per key/state block (block width = word_size*array_size = 128)
num_rounds, 10, AES rounds; store depth = num_rounds+1

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  reset, synchronous, active-high
start  input  1  request expansion of key; sampled on a rising edge
key  input  128  cipher key, FIPS-197 byte order (byte 0 = key[127:120])
rd_addr  input  4  round-key index 0..10
rd_key  output  128  round key selected by rd_addr, registered
busy  output  1  expansion in progress
ready  output  1  all 11 round keys valid
done  output  1  one-cycle pulse when expansion completes

Behaviour:
- Reset, synchronous, active-high; on a reset edge:
  - state=IDLE; busy=0, ready=0, done=0, rd_key=0.
  - Round counter=0; all 11 store entries cleared to 0.
  - Reset overrides start and any in-flight expansion; a mid-expansion reset abandons it with no partial ready/done.
- Word order: w0=key[127:96], w1=key[95:64], w2=key[63:32], w3=key[31:0]; each round key is stored in the same layout.
- Round computation, round r from round r-1 (words p0..p3):
  - t = SubWord(RotWord(p3)) ^ {Rcon[r],24'h0}.
  - RotWord: bytes {a,b,c,d}->{b,c,d,a}.
  - SubWord: AES forward S-box applied to each byte; the 256-entry S-box lookup is internal to this block.
  - n0=p0^t, n1=p1^n0, n2=p2^n1, n3=p3^n2.
  - Rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36.
- FSM states: IDLE, EXPAND, DONE.
  - IDLE/DONE, start=1 at edge E0:
    - Store slot0 := key; counter := 1.
    - busy := 1, ready := 0.
    - Go to EXPAND.
  - EXPAND, edge Ek (k=1..10):
    - Slot k := f(slot k-1, Rcon[k]); counter := counter+1.
    - At E10: busy := 0, ready := 1, done := 1; go to DONE.
  - DONE:
    - done := 0 on the next edge.
    - ready held until the next accepted start or reset.
    - Stored keys held.
  - start while busy (EXPAND) is ignored; the key input is sampled only at E0.
- Latency: start sampled at E0 -> done/ready visible after E10, i.e. 10 cycles. Back-to-back restart is allowed from DONE on the cycle after done.
- Read port:
  - rd_key := store[rd_addr] at every rising edge, giving 1-cycle latency; independent of FSM state.
  - rd_addr 11..15 -> rd_key := 0.
  - Reads during EXPAND return current slot contents, which may be stale or partially updated; consumers must wait for ready.
- Widths: all XOR logic is 32-bit per word; no carries; counter is 4 bits and never exceeds 10.

Test Plan:
1. FIPS-197 A.1: rst 2 cycles, key=2b7e151628aed2a6abf7158809cf4f3c, start 1 cycle -> busy=1 for 10 cycles; done single pulse and ready=1 exactly 10 edges after start edge. Then:
   - rd_addr=0 -> rd_key=2b7e151628aed2a6abf7158809cf4f3c.
   - rd_addr=1 -> a0fafe1788542cb123a339392a6c7605.
   - rd_addr=10 -> d014f9a8c9ee2589e13f0cc8b6630ca6.
2. Read latency/range: after case 1, rd_addr=10 then 11 on consecutive cycles -> rd_key shows round-10 key one cycle after the address, then 0 one cycle after addr 11.
3. Start while busy: start with A.1 key, then at cycle 4 start with key=000102030405060708090a0b0c0d0e0f -> ignored; done at cycle 10 and slot 10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
4. Reset mid-expansion: rst at cycle 5 of EXPAND -> next edge busy=0, ready=0, done never pulses; rd_addr=0 returns 0.
5. Restart: after completion, start with key=000102030405060708090a0b0c0d0e0f -> ready drops on start edge; after done, rd_addr=10 -> 13111d7fe3944a17f307a78b4d2b30c5.
6. All-zero key: start with key=0 -> rd_addr=1 gives 62636363626363636263636362636363.
